// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the VGA timing generator: 640x480@60 timing
//   (horizontal in pixel slots, vertical in lines), bus widths, the region
//   codes used by the horizontal and vertical decoders, and the decode helper.
//   No ports.

package vga_timing_pkg;

  localparam int CLK_DIV_DEF  = 2;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int ADDR_W  = 20;
  localparam int COLOR_W = 3;

  // Region codes, shared by the horizontal and vertical decoders.
  localparam logic [1:0] RGN_ACTIVE = 2'd0;
  localparam logic [1:0] RGN_FRONT  = 2'd1;
  localparam logic [1:0] RGN_SYNC   = 2'd2;
  localparam logic [1:0] RGN_BACK   = 2'd3;

  // Region boundaries sit at act, act+fp and act+fp+sync; everything from
  // there up to the wrap is back porch.
  function automatic logic [1:0] region_of(input int cnt, input int act,
                                           input int fp, input int sync);
    if (cnt < act)                 return RGN_ACTIVE;
    else if (cnt < act + fp)       return RGN_FRONT;
    else if (cnt < act + fp + sync) return RGN_SYNC;
    else                           return RGN_BACK;
  endfunction

endpackage

// File: rtl/pix_ce_gen.sv
// pix_ce_gen
//   Pixel-slot divider. A counter runs 0..CLK_DIV-1 and wraps; pix_ce is high
//   for the single sysclk in which the counter sits at CLK_DIV-1, so the
//   first pix_ce after reset release falls on the CLK_DIV-th edge.
// Ports
//   sysclk     in   system clock, rising edge
//   sys_rst_n  in   synchronous active-low reset
//   pix_ce     out  one-sysclk pixel enable

module pix_ce_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic sysclk,
  input  logic sys_rst_n,
  output logic pix_ce
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == DIV_LAST) div_cnt_d = '0;
  end

  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) div_cnt_q <= '0;
    else            div_cnt_q <= div_cnt_d;
  end

  assign pix_ce = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing. Horizontal/vertical slot counters advance on pix_ce,
//   a running linear address is offered to the downstream pixel source, and
//   the returned colour plus sync levels are registered one slot later so the
//   source has CLK_DIV sysclks of fetch time.
// Ports
//   sysclk         in   system clock, rising edge
//   sys_rst_n      in   synchronous active-low reset
//   display_color  in   colour for the current display_addr
//   display_addr   out  linear address of the pixel being fetched
//   vga_hsync      out  horizontal sync, active low
//   vga_vsync      out  vertical sync, active low
//   vga_rgb        out  pixel colour, 0 while blanked
//   frame_start    out  one-sysclk pulse as the raster wraps to (0,0)
//
// Region decode (h_cnt horizontally, v_cnt vertically)
//   region | meaning
//   ACTIVE | cnt < ACTIVE, visible pixels / lines
//   FRONT  | front porch
//   SYNC   | sync pulse, raw sync driven low
//   BACK   | back porch, ends at the wrap to 0

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic               sysclk,
  input  logic               sys_rst_n,
  input  logic [COLOR_W-1:0] display_color,
  output logic [ADDR_W-1:0]  display_addr,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic [COLOR_W-1:0] vga_rgb,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0]    H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]    V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic pix_ce;

  pix_ce_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_ce_gen (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .pix_ce    (pix_ce)
  );

  logic [H_W-1:0]     h_cnt_q, h_cnt_d;
  logic [V_W-1:0]     v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               frame_start_q, frame_start_d;

  logic [1:0] h_region;
  logic [1:0] v_region;
  logic       h_wrap;
  logic       v_wrap;
  logic       frame_wrap;
  logic       active;
  logic       hsync_raw;
  logic       vsync_raw;

  always_comb begin
    h_region   = region_of(int'(h_cnt_q), H_ACTIVE, H_FP, H_SYNC);
    v_region   = region_of(int'(v_cnt_q), V_ACTIVE, V_FP, V_SYNC);
    h_wrap     = (h_cnt_q == H_LAST);
    v_wrap     = (v_cnt_q == V_LAST);
    frame_wrap = h_wrap && v_wrap;
    active     = (h_region == RGN_ACTIVE) && (v_region == RGN_ACTIVE);
    hsync_raw  = (h_region != RGN_SYNC);
    vsync_raw  = (v_region != RGN_SYNC);
  end

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    addr_d        = addr_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;

    if (pix_ce) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;

      // The final active pixel leaves the address parked at its last value
      // through vertical blanking; only the frame wrap returns it to 0.
      if (frame_wrap)                          addr_d = '0;
      else if (active && addr_q != ADDR_LAST)  addr_d = addr_q + 1'b1;

      // Colour, active and sync levels of the slot just ending move to the
      // pins together, one slot behind display_addr.
      rgb_d         = active ? display_color : '0;
      hsync_d       = hsync_raw;
      vsync_d       = vsync_raw;
      frame_start_d = frame_wrap;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      addr_q        <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      addr_q        <= addr_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign display_addr = addr_q;
  assign vga_rgb      = rgb_q;
  assign vga_hsync    = hsync_q;
  assign vga_vsync    = vsync_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Bench for vga_timing_gen on a reduced raster so whole frames stay short.
//   The reference derives the raster position from the number of sysclk
//   edges since reset (position = edges / CLK_DIV), then computes address,
//   sync levels and colour from the timing rules with plain arithmetic.

module tb_vga_timing_gen;

  localparam int D  = 3;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        sysclk = 1'b0;
  logic        sys_rst_n;
  logic [2:0]  display_color;
  logic [19:0] display_addr;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [2:0]  vga_rgb;
  logic        frame_start;

  vga_timing_gen #(
    .CLK_DIV  (D),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .sysclk        (sysclk),
    .sys_rst_n     (sys_rst_n),
    .display_color (display_color),
    .display_addr  (display_addr),
    .vga_hsync     (vga_hsync),
    .vga_vsync     (vga_vsync),
    .vga_rgb       (vga_rgb),
    .frame_start   (frame_start)
  );

  always #5 sysclk = ~sysclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
  endtask

  // reference state
  int k = 0;            // edges since last reset edge
  int m_h, m_v;
  int exp_rgb = 0, exp_hs = 1, exp_vs = 1, exp_fs = 0, exp_addr = 0;

  // interval measurement
  int cyc = 0;
  int hs_fall = -1, vs_fall = -1, fs_last = -1;
  bit first_fall_pending = 1;
  logic prev_hs = 1'b1, prev_vs = 1'b1;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic step(input logic rst_n, input logic [2:0] col);
    int pos, prev, ph, pv;
    sys_rst_n     = rst_n;
    display_color = col;
    @(posedge sysclk);
    cyc++;
    k   = rst_n ? k + 1 : 0;
    pos = (k / D) % FT;
    m_h = pos % HT;
    m_v = pos / HT;
    exp_addr = imin(m_v * HA + imin(m_h, HA), HA * VA - 1);
    exp_fs   = (rst_n && (k % D == 0) && pos == 0) ? 1 : 0;
    if (!rst_n) begin
      exp_rgb = 0; exp_hs = 1; exp_vs = 1;
    end else if (k % D == 0) begin
      prev    = (pos + FT - 1) % FT;
      ph      = prev % HT;
      pv      = prev / HT;
      exp_rgb = (ph < HA && pv < VA) ? int'(col) : 0;
      exp_hs  = (ph >= HA + HF && ph < HA + HF + HS) ? 0 : 1;
      exp_vs  = (pv >= VA + VF && pv < VA + VF + VS) ? 0 : 1;
    end
    #1;
    check_val("addr",        int'(display_addr), exp_addr);
    check_val("rgb",         int'(vga_rgb),      exp_rgb);
    check_val("hsync",       int'(vga_hsync),    exp_hs);
    check_val("vsync",       int'(vga_vsync),    exp_vs);
    check_val("frame_start", int'(frame_start),  exp_fs);

    if (!rst_n) begin
      hs_fall = -1; vs_fall = -1; fs_last = -1; first_fall_pending = 1;
    end else begin
      if (prev_hs && !vga_hsync) begin
        if (first_fall_pending)  check_val("hs_first_fall", k, (HA + HF + 1) * D);
        else if (hs_fall >= 0)   check_val("hs_period", cyc - hs_fall, HT * D);
        first_fall_pending = 0;
        hs_fall = cyc;
      end
      if (!prev_hs && vga_hsync && hs_fall >= 0)
        check_val("hs_width", cyc - hs_fall, HS * D);
      if (prev_vs && !vga_vsync) vs_fall = cyc;
      if (!prev_vs && vga_vsync && vs_fall >= 0)
        check_val("vs_width", cyc - vs_fall, VS * HT * D);
      if (frame_start) begin
        if (fs_last >= 0) check_val("fs_period", cyc - fs_last, FT * D);
        fs_last = cyc;
      end
    end
    prev_hs = vga_hsync;
    prev_vs = vga_vsync;
  endtask

  task automatic run_until(input int h, input int v, input logic [2:0] col);
    int n = 0;
    while (!(m_h == h && m_v == v && k % D == 1) && n < 4 * FT * D) begin
      step(1'b1, col);
      n++;
    end
    check_val("reach_pos", (n < 4 * FT * D) ? 1 : 0, 1);
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    display_color = 3'b000;

    for (int i = 0; i < 4; i++) step(1'b0, 3'($urandom));

    // random colour every sysclk across more than two frames
    for (int i = 0; i < 5 * FT * D / 2; i++) step(1'b1, 3'($urandom));

    // mid-line reset, then two clean frames with a changing colour
    run_until(5, 2, 3'($urandom));
    step(1'b0, 3'($urandom));
    for (int i = 0; i < 2 * FT * D + 20; i++) step(1'b1, 3'($urandom));

    // constant white: rgb must be 111 only in delayed active slots
    for (int i = 0; i < FT * D + 10; i++) step(1'b1, 3'b111);

    // colour stepped once per slot
    for (int i = 0; i < FT; i++) begin
      logic [2:0] c;
      c = 3'($urandom);
      for (int j = 0; j < D; j++) step(1'b1, c);
    end

    // reset at a random point, multi-cycle, then run again
    for (int i = 0; i < int'($urandom_range(FT * D - 1, 1)); i++) step(1'b1, 3'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 3'($urandom));
    for (int i = 0; i < 2 * FT * D + 5; i++) step(1'b1, 3'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
